// File: rtl/cache_axi_bridge_pkg.sv
// Shared request codes, AXI constants and bridge FSM states.
package cache_axi_bridge_pkg;

  localparam logic       REQ_READ       = 1'b0;
  localparam logic       REQ_WRITE      = 1'b1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane write strobe from AXI size code and start-address byte offset.
// Full-width beats enable every lane; narrower beats place a size-wide mask at the offset.
module axi_wstrb_gen #(
  parameter int STRB_W = 8
) (
  input  logic [1:0]        size_i,
  input  logic [2:0]        addr_i,
  output logic [STRB_W-1:0] strb_o
);

  logic [STRB_W-1:0] base;

  always_comb begin
    base = '0;
    case (size_i)
      2'd0:    base = STRB_W'(8'h01);
      2'd1:    base = STRB_W'(8'h03);
      2'd2:    base = STRB_W'(8'h0F);
      default: base = '1;
    endcase
    strb_o = (size_i == 2'd3) ? '1 : (base << addr_i);
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Turns one cache line request into a single AXI4 INCR burst and returns the line.
// One transaction in flight; completion is a one-cycle ready pulse carrying rdata/err.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LINE_W = 512,
  parameter int ID     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cache_rw_axi_valid,
  input  logic                i_cache_rw_axi_op,
  input  logic [LINE_W-1:0]   i_cache_rw_axi_wdata,
  input  logic [63:0]         i_cache_rw_axi_addr,
  input  logic [1:0]          i_cache_rw_axi_size,
  input  logic [7:0]          i_cache_rw_axi_blks,
  output logic                o_cache_rw_axi_ready,
  output logic [LINE_W-1:0]   o_cache_rw_axi_rdata,
  output logic                o_cache_rw_axi_err,
  output logic                o_axi_aw_valid,
  output logic [63:0]         o_axi_aw_addr,
  output logic [7:0]          o_axi_aw_len,
  output logic [2:0]          o_axi_aw_size,
  output logic [1:0]          o_axi_aw_burst,
  output logic [3:0]          o_axi_aw_id,
  input  logic                i_axi_aw_ready,
  output logic                o_axi_w_valid,
  output logic [DATA_W-1:0]   o_axi_w_data,
  output logic [DATA_W/8-1:0] o_axi_w_strb,
  output logic                o_axi_w_last,
  input  logic                i_axi_w_ready,
  input  logic                i_axi_b_valid,
  input  logic [1:0]          i_axi_b_resp,
  output logic                o_axi_b_ready,
  output logic                o_axi_ar_valid,
  output logic [63:0]         o_axi_ar_addr,
  output logic [7:0]          o_axi_ar_len,
  output logic [2:0]          o_axi_ar_size,
  output logic [1:0]          o_axi_ar_burst,
  output logic [3:0]          o_axi_ar_id,
  input  logic                i_axi_ar_ready,
  input  logic                i_axi_r_valid,
  input  logic [DATA_W-1:0]   i_axi_r_data,
  input  logic [1:0]          i_axi_r_resp,
  input  logic                i_axi_r_last,
  output logic                o_axi_r_ready
);

  localparam int NBEATS = LINE_W / DATA_W;
  localparam int LANE_W = $clog2(NBEATS);

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [63:0]         addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [7:0]          blks_q, blks_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [8:0]          beat_q, beat_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [LANE_W-1:0]   lane;
  logic                lane_ok;
  logic                beat_in_burst;

  // beat_q saturates at blks+1 on reads, so 9 bits never wraps even for illegal blks.
  assign lane          = beat_q[LANE_W-1:0];
  assign lane_ok       = (beat_q < 9'(NBEATS));
  assign beat_in_burst = (beat_q <= {1'b0, blks_q});

  assign o_axi_aw_addr  = addr_q;
  assign o_axi_aw_len   = blks_q;
  assign o_axi_aw_size  = {1'b0, size_q};
  assign o_axi_aw_burst = AXI_BURST_INCR;
  assign o_axi_aw_id    = 4'(ID);
  assign o_axi_ar_addr  = addr_q;
  assign o_axi_ar_len   = blks_q;
  assign o_axi_ar_size  = {1'b0, size_q};
  assign o_axi_ar_burst = AXI_BURST_INCR;
  assign o_axi_ar_id    = 4'(ID);

  assign o_axi_w_data = lane_ok ? wdata_q[lane*DATA_W +: DATA_W] : '0;
  assign o_axi_w_last = (beat_q == {1'b0, blks_q});

  assign o_cache_rw_axi_rdata = rdata_q;
  assign o_cache_rw_axi_err   = err_q;

  axi_wstrb_gen #(
    .STRB_W (DATA_W/8)
  ) u_wstrb (
    .size_i (size_q),
    .addr_i (addr_q[2:0]),
    .strb_o (o_axi_w_strb)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    size_d    = size_q;
    blks_d    = blks_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    o_axi_aw_valid       = 1'b0;
    o_axi_w_valid        = 1'b0;
    o_axi_b_ready        = 1'b0;
    o_axi_ar_valid       = 1'b0;
    o_axi_r_ready        = 1'b0;
    o_cache_rw_axi_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cache_rw_axi_valid) begin
          op_d      = i_cache_rw_axi_op;
          addr_d    = i_cache_rw_axi_addr;
          size_d    = i_cache_rw_axi_size;
          blks_d    = i_cache_rw_axi_blks;
          wdata_d   = i_cache_rw_axi_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          beat_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (i_cache_rw_axi_op == REQ_WRITE) ? ST_WR : ST_RD_ADDR;
        end
      end

      ST_RD_ADDR: begin
        o_axi_ar_valid = 1'b1;
        if (i_axi_ar_ready) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        o_axi_r_ready = 1'b1;
        if (i_axi_r_valid) begin
          // Surplus beats past blks+1 are consumed but never stored.
          if (beat_in_burst) begin
            if (lane_ok) rdata_d[lane*DATA_W +: DATA_W] = i_axi_r_data;
            beat_d = beat_q + 9'd1;
          end
          if (i_axi_r_resp != AXI_RESP_OKAY) err_d = 1'b1;
          if (i_axi_r_last) state_d = ST_DONE;
        end
      end

      ST_WR: begin
        o_axi_aw_valid = !aw_done_q;
        o_axi_w_valid  = !w_done_q;
        if (o_axi_aw_valid && i_axi_aw_ready) aw_done_d = 1'b1;
        if (o_axi_w_valid && i_axi_w_ready) begin
          if (o_axi_w_last) w_done_d = 1'b1;
          else              beat_d   = beat_q + 9'd1;
        end
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end

      ST_WR_RESP: begin
        o_axi_b_ready = 1'b1;
        if (i_axi_b_valid) begin
          if (i_axi_b_resp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        o_cache_rw_axi_ready = 1'b1;
        state_d              = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= REQ_READ;
      addr_q    <= '0;
      size_q    <= '0;
      blks_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      blks_q    <= blks_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Bench for cache_axi_bridge: directed vector table, reset-abort sequence and
// randomized transactions against a line-level reference model.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cache_rw_axi_valid;
  logic         i_cache_rw_axi_op;
  logic [511:0] i_cache_rw_axi_wdata;
  logic [63:0]  i_cache_rw_axi_addr;
  logic [1:0]   i_cache_rw_axi_size;
  logic [7:0]   i_cache_rw_axi_blks;
  logic         o_cache_rw_axi_ready;
  logic [511:0] o_cache_rw_axi_rdata;
  logic         o_cache_rw_axi_err;
  logic         o_axi_aw_valid;
  logic [63:0]  o_axi_aw_addr;
  logic [7:0]   o_axi_aw_len;
  logic [2:0]   o_axi_aw_size;
  logic [1:0]   o_axi_aw_burst;
  logic [3:0]   o_axi_aw_id;
  logic         i_axi_aw_ready;
  logic         o_axi_w_valid;
  logic [63:0]  o_axi_w_data;
  logic [7:0]   o_axi_w_strb;
  logic         o_axi_w_last;
  logic         i_axi_w_ready;
  logic         i_axi_b_valid;
  logic [1:0]   i_axi_b_resp;
  logic         o_axi_b_ready;
  logic         o_axi_ar_valid;
  logic [63:0]  o_axi_ar_addr;
  logic [7:0]   o_axi_ar_len;
  logic [2:0]   o_axi_ar_size;
  logic [1:0]   o_axi_ar_burst;
  logic [3:0]   o_axi_ar_id;
  logic         i_axi_ar_ready;
  logic         i_axi_r_valid;
  logic [63:0]  i_axi_r_data;
  logic [1:0]   i_axi_r_resp;
  logic         i_axi_r_last;
  logic         o_axi_r_ready;

  cache_axi_bridge #(.DATA_W(64), .LINE_W(512), .ID(0)) dut (
    .clk(clk), .rst(rst),
    .i_cache_rw_axi_valid(i_cache_rw_axi_valid), .i_cache_rw_axi_op(i_cache_rw_axi_op),
    .i_cache_rw_axi_wdata(i_cache_rw_axi_wdata), .i_cache_rw_axi_addr(i_cache_rw_axi_addr),
    .i_cache_rw_axi_size(i_cache_rw_axi_size), .i_cache_rw_axi_blks(i_cache_rw_axi_blks),
    .o_cache_rw_axi_ready(o_cache_rw_axi_ready), .o_cache_rw_axi_rdata(o_cache_rw_axi_rdata),
    .o_cache_rw_axi_err(o_cache_rw_axi_err),
    .o_axi_aw_valid(o_axi_aw_valid), .o_axi_aw_addr(o_axi_aw_addr), .o_axi_aw_len(o_axi_aw_len),
    .o_axi_aw_size(o_axi_aw_size), .o_axi_aw_burst(o_axi_aw_burst), .o_axi_aw_id(o_axi_aw_id),
    .i_axi_aw_ready(i_axi_aw_ready),
    .o_axi_w_valid(o_axi_w_valid), .o_axi_w_data(o_axi_w_data), .o_axi_w_strb(o_axi_w_strb),
    .o_axi_w_last(o_axi_w_last), .i_axi_w_ready(i_axi_w_ready),
    .i_axi_b_valid(i_axi_b_valid), .i_axi_b_resp(i_axi_b_resp), .o_axi_b_ready(o_axi_b_ready),
    .o_axi_ar_valid(o_axi_ar_valid), .o_axi_ar_addr(o_axi_ar_addr), .o_axi_ar_len(o_axi_ar_len),
    .o_axi_ar_size(o_axi_ar_size), .o_axi_ar_burst(o_axi_ar_burst), .o_axi_ar_id(o_axi_ar_id),
    .i_axi_ar_ready(i_axi_ar_ready),
    .i_axi_r_valid(i_axi_r_valid), .i_axi_r_data(i_axi_r_data), .i_axi_r_resp(i_axi_r_resp),
    .i_axi_r_last(i_axi_r_last), .o_axi_r_ready(o_axi_r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          op;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  blks;
    int          nsent;      // R beats the slave returns, rlast on the final one
    int          ar_dly;
    int          aw_dly;
    int          b_dly;
    int          rmode;      // 0 always valid, 1 every other cycle, 2 random
    int          wmode;      // 0 always ready, 2 random
    logic [1:0]  bresp;
    int          bad_rbeat;  // R beat index carrying SLVERR, -1 for none
    logic [31:0] tag;
    bit          drop;       // drop request valid right after acceptance
  } txn_t;

  typedef struct {
    txn_t       t;
    int         exp_lat;
    bit         exp_err;
    logic [7:0] exp_strb;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  int           r_lat;
  logic [511:0] r_rdata;
  logic         r_err;
  logic [63:0]  w_dat [16];
  logic [7:0]   w_strb[16];
  logic         w_last[16];
  int           w_cnt;
  int           g_ar_hs, g_aw_hs;
  bit           proto_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkl(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mkt(bit op, logic [63:0] addr, logic [1:0] size, logic [7:0] blks,
                               int nsent, int ar_dly, int aw_dly, int b_dly, int rmode,
                               logic [1:0] bresp, int bad, logic [31:0] tag);
    txn_t t;
    t.op = op; t.addr = addr; t.size = size; t.blks = blks; t.nsent = nsent;
    t.ar_dly = ar_dly; t.aw_dly = aw_dly; t.b_dly = b_dly; t.rmode = rmode; t.wmode = 0;
    t.bresp = bresp; t.bad_rbeat = bad; t.tag = tag; t.drop = 1'b0;
    return t;
  endfunction

  function automatic vec_t mkv(txn_t t, int lat, bit err, logic [7:0] strb);
    vec_t v;
    v.t = t; v.exp_lat = lat; v.exp_err = err; v.exp_strb = strb;
    return v;
  endfunction

  function automatic logic [511:0] mk_line(input logic [63:0] salt);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = (64'h1111_1111_1111_1111 * 64'(k)) ^ salt;
    return l;
  endfunction

  function automatic logic [7:0] strb_model(input logic [1:0] size, input logic [63:0] addr);
    logic [15:0] m;
    if (size == 2'd3) return 8'hFF;
    m = 16'((1 << (1 << size)) - 1) << addr[2:0];
    return m[7:0];
  endfunction

  task automatic slave_idle();
    i_axi_aw_ready = 0; i_axi_w_ready = 0; i_axi_b_valid = 0; i_axi_b_resp = 0;
    i_axi_ar_ready = 0; i_axi_r_valid = 0; i_axi_r_data = 0; i_axi_r_resp = 0; i_axi_r_last = 0;
  endtask

  // Emulates an AXI slave around one request; called at a negedge with the DUT idle.
  task automatic run_txn(input txn_t t, input logic [511:0] wline);
    int ar_wait = 0, aw_wait = 0, b_wait = 0, r_sent = 0, r_cyc = 0;
    bit ar_pend = 0, aw_pend = 0, w_pend = 0, done = 0, rv, wr;
    logic [74:0] ar_snap = '0, aw_snap = '0;
    logic [72:0] w_snap = '0;
    w_cnt = 0; g_ar_hs = 0; g_aw_hs = 0; proto_ok = 1; r_lat = -1; r_rdata = '0; r_err = 0;
    i_cache_rw_axi_valid = 1; i_cache_rw_axi_op = t.op; i_cache_rw_axi_wdata = wline;
    i_cache_rw_axi_addr = t.addr; i_cache_rw_axi_size = t.size; i_cache_rw_axi_blks = t.blks;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      if (t.drop) i_cache_rw_axi_valid = 0;
      if (ar_pend && (!o_axi_ar_valid || {o_axi_ar_addr, o_axi_ar_len, o_axi_ar_size} != ar_snap)) proto_ok = 0;
      if (aw_pend && (!o_axi_aw_valid || {o_axi_aw_addr, o_axi_aw_len, o_axi_aw_size} != aw_snap)) proto_ok = 0;
      if (w_pend && (!o_axi_w_valid || {o_axi_w_data, o_axi_w_strb, o_axi_w_last} != w_snap)) proto_ok = 0;
      if (o_cache_rw_axi_ready) begin
        r_lat = cyc; r_rdata = o_cache_rw_axi_rdata; r_err = o_cache_rw_axi_err; done = 1;
        i_cache_rw_axi_valid = 0;
        slave_idle();
        @(negedge clk);
        chk("ready_pulse_width", 64'(o_cache_rw_axi_ready), 64'(0));
      end else begin
        if (o_axi_ar_valid) begin
          if (ar_wait == 0) begin
            chk("araddr", o_axi_ar_addr, t.addr);
            chk("arlen", 64'(o_axi_ar_len), 64'(t.blks));
            chk("arsize", 64'(o_axi_ar_size), 64'({1'b0, t.size}));
            chk("arburst_arid", 64'({o_axi_ar_burst, o_axi_ar_id}), 64'({2'b01, 4'd0}));
          end
          i_axi_ar_ready = (ar_wait >= t.ar_dly); ar_wait++;
          if (i_axi_ar_ready) g_ar_hs++;
          ar_snap = {o_axi_ar_addr, o_axi_ar_len, o_axi_ar_size}; ar_pend = !i_axi_ar_ready;
        end else begin
          i_axi_ar_ready = 0; ar_pend = 0;
        end
        if (o_axi_r_ready && r_sent < t.nsent) begin
          case (t.rmode)
            0:       rv = 1;
            1:       rv = (r_cyc % 2) == 1;
            default: rv = 1'($urandom_range(0, 1));
          endcase
          r_cyc++;
          i_axi_r_valid = rv;
          if (rv) begin
            i_axi_r_data = {t.tag, 32'(r_sent)};
            i_axi_r_resp = (r_sent == t.bad_rbeat) ? 2'b10 : 2'b00;
            i_axi_r_last = (r_sent == t.nsent - 1);
            r_sent++;
          end
        end else begin
          i_axi_r_valid = 0;
        end
        if (o_axi_aw_valid) begin
          if (aw_wait == 0) begin
            chk("awaddr", o_axi_aw_addr, t.addr);
            chk("awlen", 64'(o_axi_aw_len), 64'(t.blks));
            chk("awsize_burst_id", 64'({o_axi_aw_size, o_axi_aw_burst, o_axi_aw_id}),
                64'({1'b0, t.size, 2'b01, 4'd0}));
          end
          i_axi_aw_ready = (aw_wait >= t.aw_dly); aw_wait++;
          if (i_axi_aw_ready) g_aw_hs++;
          aw_snap = {o_axi_aw_addr, o_axi_aw_len, o_axi_aw_size}; aw_pend = !i_axi_aw_ready;
        end else begin
          i_axi_aw_ready = 0; aw_pend = 0;
        end
        if (o_axi_w_valid) begin
          wr = (t.wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          i_axi_w_ready = wr;
          if (wr) begin
            if (w_cnt < 16) begin
              w_dat[w_cnt] = o_axi_w_data; w_strb[w_cnt] = o_axi_w_strb; w_last[w_cnt] = o_axi_w_last;
            end
            w_cnt++;
          end
          w_snap = {o_axi_w_data, o_axi_w_strb, o_axi_w_last}; w_pend = !wr;
        end else begin
          i_axi_w_ready = 0; w_pend = 0;
        end
        if (o_axi_b_ready) begin
          i_axi_b_valid = (b_wait >= t.b_dly); i_axi_b_resp = t.bresp; b_wait++;
        end else begin
          i_axi_b_valid = 0;
        end
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL txn_timeout: no ready within 400 cycles (op %0d tag %0d)", t.op, t.tag);
      i_cache_rw_axi_valid = 0;
      slave_idle();
    end
  endtask

  // Line-level expectations: what the cache should see and what the slave should receive.
  task automatic check_txn(input txn_t t, input logic [511:0] wline, input logic [7:0] exp_strb,
                           input string pfx);
    logic [511:0] er = '0;
    logic [63:0]  ed;
    bit           ee;
    int           nb;
    if (t.op == 1'b0) begin
      nb = t.nsent;
      if (nb > int'(t.blks) + 1) nb = int'(t.blks) + 1;
      if (nb > 8) nb = 8;
      for (int k = 0; k < nb; k++) er[k*64 +: 64] = {t.tag, 32'(k)};
      ee = (t.bad_rbeat >= 0) && (t.bad_rbeat < t.nsent);
    end else begin
      ee = (t.bresp != 2'b00);
    end
    chk({pfx, ".err"}, 64'(r_err), 64'(ee));
    chkl({pfx, ".rdata"}, r_rdata, er);
    chk({pfx, ".protocol_stable"}, 64'(proto_ok), 64'(1));
    chk({pfx, ".ar_count"}, 64'(g_ar_hs), 64'(t.op == 1'b0));
    chk({pfx, ".aw_count"}, 64'(g_aw_hs), 64'(t.op == 1'b1));
    chk({pfx, ".w_count"}, 64'(w_cnt), (t.op == 1'b1) ? 64'(int'(t.blks) + 1) : 64'(0));
    for (int k = 0; k < w_cnt && k < 16; k++) begin
      ed = (k < 8) ? wline[k*64 +: 64] : 64'(0);
      chk($sformatf("%s.wdata%0d", pfx, k), w_dat[k], ed);
      chk($sformatf("%s.wstrb%0d", pfx, k), 64'(w_strb[k]), 64'(exp_strb));
      chk($sformatf("%s.wlast%0d", pfx, k), 64'(w_last[k]), 64'(k == int'(t.blks)));
    end
  endtask

  vec_t         vecs[10];
  txn_t         t;
  logic [511:0] wl;
  int           k;

  initial begin
    rst = 0;
    i_cache_rw_axi_valid = 0; i_cache_rw_axi_op = 0; i_cache_rw_axi_wdata = '0;
    i_cache_rw_axi_addr = 0; i_cache_rw_axi_size = 0; i_cache_rw_axi_blks = 0;
    slave_idle();

    repeat (3) @(negedge clk);
    chk("reset_valids", 64'({o_axi_aw_valid, o_axi_w_valid, o_axi_b_ready, o_axi_ar_valid,
                             o_axi_r_ready, o_cache_rw_axi_ready}), 64'(0));
    chkl("reset_rdata", o_cache_rw_axi_rdata, '0);
    chk("reset_err", 64'(o_cache_rw_axi_err), 64'(0));
    rst = 1;
    @(negedge clk);

    //          op  addr                  sz   blks  ns ar aw b rm bresp bad  tag       lat err strb
    vecs[0] = mkv(mkt(0, 64'h8000_0000, 2'd3, 8'd7, 8, 0, 0, 0, 0, 2'b00, -1, 32'd0), 10, 0, 8'hFF);
    vecs[1] = mkv(mkt(1, 64'h8000_0000, 2'd3, 8'd7, 0, 0, 3, 0, 0, 2'b00, -1, 32'd1), 10, 0, 8'hFF);
    vecs[2] = mkv(mkt(1, 64'h8000_0040, 2'd3, 8'd7, 0, 0, 0, 0, 0, 2'b10, -1, 32'd2), 10, 1, 8'hFF);
    vecs[3] = mkv(mkt(0, 64'h8000_0000, 2'd3, 8'd7, 8, 5, 0, 0, 1, 2'b00, -1, 32'd0), 23, 0, 8'hFF);
    vecs[4] = mkv(mkt(1, 64'h8000_0004, 2'd2, 8'd0, 0, 0, 0, 0, 0, 2'b00, -1, 32'd4), 3, 0, 8'hF0);
    vecs[5] = mkv(mkt(0, 64'h8000_0100, 2'd3, 8'd3, 2, 0, 0, 0, 0, 2'b00, -1, 32'd5), 4, 0, 8'hFF);
    vecs[6] = mkv(mkt(0, 64'h8000_0200, 2'd3, 8'd1, 4, 0, 0, 0, 0, 2'b00, -1, 32'd6), 6, 0, 8'hFF);
    vecs[7] = mkv(mkt(0, 64'h8000_0300, 2'd3, 8'd7, 8, 0, 0, 0, 0, 2'b00, 4, 32'd7), 10, 1, 8'hFF);
    vecs[8] = mkv(mkt(1, 64'h8000_0102, 2'd1, 8'd2, 0, 0, 0, 0, 0, 2'b00, -1, 32'd8), 5, 0, 8'h0C);
    vecs[9] = mkv(mkt(1, 64'h8000_0007, 2'd0, 8'd0, 0, 0, 0, 2, 0, 2'b00, -1, 32'd9), 5, 0, 8'h80);

    for (int i = 0; i < 10; i++) begin
      wl = mk_line((i == 1) ? 64'd0 : 64'(i) * 64'h0F0F_0000_0000_0001);
      run_txn(vecs[i].t, wl);
      chk($sformatf("v%0d.latency", i), 64'(r_lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d.err_table", i), 64'(r_err), 64'(vecs[i].exp_err));
      check_txn(vecs[i].t, wl, vecs[i].exp_strb, $sformatf("v%0d", i));
    end

    // Reset asserted mid read burst while beat 3 is on the bus.
    i_cache_rw_axi_valid = 1; i_cache_rw_axi_op = 0; i_cache_rw_axi_addr = 64'h8000_0000;
    i_cache_rw_axi_size = 2'd3; i_cache_rw_axi_blks = 8'd7;
    i_axi_ar_ready = 1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      i_cache_rw_axi_valid = 0;
      if (o_axi_r_ready) begin
        i_axi_r_valid = 1; i_axi_r_data = 64'hBEEF_0000 + 64'(k); i_axi_r_resp = 2'b10;
        i_axi_r_last = 0; k++;
      end else begin
        i_axi_r_valid = 0;
      end
    end
    chk("rst_mid.beats_reached", 64'(k), 64'(4));
    #2 rst = 0;
    #1;
    chk("rst_mid.valids", 64'({o_axi_aw_valid, o_axi_w_valid, o_axi_b_ready, o_axi_ar_valid,
                               o_axi_r_ready, o_cache_rw_axi_ready}), 64'(0));
    chkl("rst_mid.rdata", o_cache_rw_axi_rdata, '0);
    chk("rst_mid.err", 64'(o_cache_rw_axi_err), 64'(0));
    slave_idle();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid.idle_after", 64'({o_axi_ar_valid, o_axi_r_ready, o_cache_rw_axi_ready}), 64'(0));
    run_txn(vecs[0].t, '0);
    chk("post_rst.latency", 64'(r_lat), 64'(10));
    check_txn(vecs[0].t, '0, 8'hFF, "post_rst");

    for (int i = 0; i < 40; i++) begin
      t.op = 1'($urandom_range(0, 1));
      t.size = 2'($urandom_range(0, 3));
      t.blks = 8'($urandom_range(0, 7));
      t.addr = 64'h8000_0000 + 64'($urandom_range(0, 65535));
      t.addr = t.addr & ~((64'd1 << t.size) - 64'd1);
      t.nsent = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(t.blks) + 3)) : int'(t.blks) + 1;
      t.ar_dly = int'($urandom_range(0, 4)); t.aw_dly = int'($urandom_range(0, 4));
      t.b_dly = int'($urandom_range(0, 4));
      t.rmode = int'($urandom_range(0, 2)); t.wmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      t.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.bad_rbeat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t.nsent - 1)) : -1;
      t.tag = 32'(100 + i);
      t.drop = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) wl[j*32 +: 32] = $urandom;
      run_txn(t, wl);
      check_txn(t, wl, strb_model(t.size, t.addr), $sformatf("r%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
